// File: rtl/formula_arg_throttle.sv
// Credit-throttled argument issuer: queues {a,b,c} sets in a small FIFO and
// releases them downstream only while the number of unanswered sets is below MAX_OUT.
module formula_arg_throttle #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_vld,
    output logic                             in_rdy,
    input  logic [WIDTH-1:0]                 in_a,
    input  logic [WIDTH-1:0]                 in_b,
    input  logic [WIDTH-1:0]                 in_c,
    output logic                             arg_vld,
    output logic [WIDTH-1:0]                 a,
    output logic [WIDTH-1:0]                 b,
    output logic [WIDTH-1:0]                 c,
    input  logic                             res_vld,
    output logic [$clog2(MAX_OUT+1)-1:0]     outstanding,
    output logic                             busy,
    output logic                             err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [3*WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [CW-1:0]      r_count;
    logic [OW-1:0]      r_out;
    logic               r_live, r_err, r_arg_vld;
    logic [WIDTH-1:0]   r_a, r_b, r_c;

    logic w_full, w_empty, w_credit, w_push, w_pop;

    // r_live holds in_rdy low through reset and for the first edge after release
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_rdy   = r_live & ~w_full;
    assign w_credit = (r_out < OW'(MAX_OUT)) | res_vld;
    assign w_push   = in_vld & in_rdy;
    assign w_pop    = ~w_empty & w_credit;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {in_a, in_b, in_c};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arg_vld <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
        end else begin
            r_arg_vld <= w_pop;
            if (w_pop) {r_a, r_b, r_c} <= r_mem[r_rptr];
        end
    end

    // A result arriving alongside an issue is a credit swap: counter holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else if (w_pop && !res_vld) begin
            r_out <= r_out + OW'(1);
        end else if (!w_pop && res_vld) begin
            if (r_out != '0) r_out <= r_out - OW'(1);
            else             r_err <= 1'b1;
        end
    end

    assign arg_vld     = r_arg_vld;
    assign a           = r_a;
    assign b           = r_b;
    assign c           = r_c;
    assign outstanding = r_out;
    assign err         = r_err;
    assign busy        = ~w_empty | (r_out != '0);

endmodule

// File: tb/tb_formula_arg_throttle.sv
// Randomized + directed bench for formula_arg_throttle against a queue-based reference model.
module tb_formula_arg_throttle;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_vld = 1'b0, res_vld = 1'b0;
    logic             in_rdy, arg_vld, busy, err;
    logic [WIDTH-1:0] in_a = '0, in_b = '0, in_c = '0, a, b, c;
    logic [2:0]       outstanding;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [3*WIDTH-1:0] mq[$];
    int                 m_out;
    bit                 m_err, m_vld, m_live, m_acc;
    logic [WIDTH-1:0]   ea, eb, ec;
    int                 d_log[$];
    int                 n_vld;

    formula_arg_throttle #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .arg_vld(arg_vld), .a(a), .b(b), .c(c),
        .res_vld(res_vld), .outstanding(outstanding), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = 0; m_err = 0; m_vld = 0; m_live = 0;
        ea = '0; eb = '0; ec = '0;
    endtask

    // One clock: drive inputs, advance the model over the edge, compare all outputs.
    task automatic step(input bit v, input logic [WIDTH-1:0] va, input bit rv);
        bit push, issue;
        logic [3*WIDTH-1:0] s;
        in_vld = v; in_a = va; in_b = va * 3; in_c = va * 7; res_vld = rv;
        @(posedge clk);
        push  = v && m_live && (mq.size() < DEPTH);
        issue = (mq.size() > 0) && (m_out < MAX_OUT || rv);
        m_vld = issue;
        if (issue) begin
            s = mq.pop_front();
            {ea, eb, ec} = s;
        end
        if (push) mq.push_back({va, va * WIDTH'(3), va * WIDTH'(7)});
        m_acc = push;
        if (issue && !rv) m_out++;
        else if (!issue && rv) begin
            if (m_out > 0) m_out--;
            else m_err = 1;
        end
        m_live = 1;
        #1;
        chk("arg_vld", 64'(arg_vld), 64'(m_vld));
        chk("a", 64'(a), 64'(ea));
        chk("b", 64'(b), 64'(eb));
        chk("c", 64'(c), 64'(ec));
        chk("outstanding", 64'(outstanding), 64'(m_out));
        chk("in_rdy", 64'(in_rdy), 64'(m_live && mq.size() < DEPTH));
        chk("busy", 64'(busy), 64'(mq.size() > 0 || m_out > 0));
        chk("err", 64'(err), 64'(m_err));
        if (arg_vld) begin
            d_log.push_back(int'(a));
            n_vld++;
        end
        in_vld = 0; res_vld = 0;
    endtask

    task automatic push_wait(input logic [WIDTH-1:0] va, input bit credit);
        for (int i = 0; i < 30; i++) begin
            step(1'b1, va, credit && m_out > 0 && ($urandom % 2 == 0));
            if (m_acc) return;
        end
        chk("push_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (mq.size() == 0 && m_out == 0) return;
            step(1'b0, '0, m_out > 0);
        end
        chk("drain_timeout", 64'(0), 64'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_rdy"}, 64'(in_rdy), 64'(0));
        chk({tag, "_arg_vld"}, 64'(arg_vld), 64'(0));
        chk({tag, "_abc"}, 64'({a, b} | 64'(c)), 64'(0));
        chk({tag, "_out"}, 64'(outstanding), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        int base;
        model_reset();
        #1 rst = 1'b1;
        #1 chk_reset_outputs("por");
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;

        // Single set (4,9,16), result returned 3 cycles after arg_vld
        step(1'b0, '0, 1'b0);
        chk("first_rdy", 64'(in_rdy), 64'(1));
        in_vld = 1; in_a = 4; in_b = 9; in_c = 16;
        @(posedge clk); #1;
        in_vld = 0;
        chk("single_no_bypass", 64'(arg_vld), 64'(0));
        @(posedge clk); #1;
        chk("single_vld", 64'(arg_vld), 64'(1));
        chk("single_abc", 64'({a, b, c}), 64'({32'd4, 32'd9, 32'd16}) & 64'hFFFF_FFFF_FFFF_FFFF);
        chk("single_c", 64'(c), 64'(16));
        chk("single_out1", 64'(outstanding), 64'(1));
        // model catch-up: the set is now in flight
        m_out = 1; m_vld = 1; ea = 4; eb = 9; ec = 16;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("single_out0", 64'(outstanding), 64'(0));
        step(1'b0, '0, 1'b0);
        chk("single_busy", 64'(busy), 64'(0));

        // Credit stall: 6 sets, no results
        n_vld = 0;
        for (int i = 0; i < 6; i++) push_wait(WIDTH'(100 + i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        chk("stall_pulses", 64'(n_vld), 64'(4));
        chk("stall_out", 64'(outstanding), 64'(4));
        step(1'b0, '0, 1'b1);
        chk("stall_swap_vld", 64'(arg_vld), 64'(1));
        chk("stall_swap_a", 64'(a), 64'(104));
        chk("stall_swap_out", 64'(outstanding), 64'(4));
        drain();

        // Full FIFO and pointer wrap with credits exhausted
        for (int i = 0; i < 4; i++) push_wait(WIDTH'(200 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        d_log.delete();
        for (int v = 1; v <= 4; v++) push_wait(WIDTH'(v), 1'b0);
        step(1'b0, '0, 1'b0);
        chk("full_rdy", 64'(in_rdy), 64'(0));
        for (int v = 5; v <= 12; v++) push_wait(WIDTH'(v), 1'b1);
        drain();
        chk("wrap_len", 64'(d_log.size()), 64'(12));
        for (int i = 0; i < d_log.size() && i < 12; i++) chk("wrap_seq", 64'(d_log[i]), 64'(i + 1));

        // Spurious result on idle block
        step(1'b0, '0, 1'b1);
        chk("spur_out", 64'(outstanding), 64'(0));
        chk("spur_err", 64'(err), 64'(1));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        chk("spur_sticky", 64'(err), 64'(1));

        // Reset mid-stream with sets queued and in flight
        for (int i = 0; i < 7; i++) push_wait(WIDTH'(300 + i), 1'b0);
        #3 rst = 1'b1;
        #1 chk_reset_outputs("mid");
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        d_log.delete();
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        chk("no_stale", 64'(d_log.size()), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            base = int'($urandom);
            step($urandom % 3 != 0, WIDTH'(base), m_out > 0 && ($urandom % 3 == 0));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
